muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
Sequencing controller for the iterative Mult and Div units and owner of the architectural HI/LO registers. Accepts decoded HI/LO-class ops from the execute stage, launches the multiplier or divider, and commits results to HI/LO. Serves MFHI/MFLO/MTHI/MTLO and raises stall only when a HI/LO-dependent op meets an in-flight operation. Also handles pipeline flush and a watchdog timeout.

Parameters:
WIDTH, 32, operand/HI/LO width
TIMEOUT_CYCLES, 64, max busy cycles before abort (must be >= worst-case unit latency + 2)
CNT_W, 7, watchdog counter width (holds TIMEOUT_CYCLES)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  HI/LO-class op present this cycle
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
flush  in  1  abort in-flight op, ignore op this cycle
srca  in  WIDTH  rs value
srcb  in  WIDTH  rt value
stall  out  1  hold issuing stage, combinational
rdata  out  WIDTH  HI (op=110) or LO (op=111), else 0, combinational
mul_start  out  1  one-cycle launch pulse to Mult (validIn)
mul_sign  out  1  1 = MULT, 0 = MULTU, held while busy
div_start  out  1  one-cycle launch pulse to Div (validIn)
div_sign  out  1  1 = DIV, 0 = DIVU, held while busy
opa  out  WIDTH  latched operand A, stable while busy
opb  out  WIDTH  latched operand B, stable while busy
mul_done  in  1  Mult validOut
mul_hi, mul_lo  in  WIDTH  Mult result
div_done  in  1  Div validOut
div_hi, div_lo  in  WIDTH  remainder / quotient
busy  out  1  state != IDLE
div0  out  1  one-cycle pulse: DIV/DIVU with srcb==0 accepted
timeout_err  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (async, reset_n=0): state IDLE; HI=LO=0; opa=opb=0; mul_start=div_start=mul_sign=div_sign=0; div0=timeout_err=0; watchdog counter=0. stall, busy and rdata follow from this state.
- FSM states: IDLE, MUL_BUSY, DIV_BUSY.
- Acceptance: an op is accepted when op_valid=1, flush=0 and stall=0.
- Stall: stall = op_valid & !flush & (state != IDLE). Applies to every op code. Non-HI/LO instructions never reach this block, so MULT/DIV is non-blocking for independent code.
- IDLE + accepted MULT/MULTU: latch opa=srca, opb=srcb, mul_sign=!op[0]. Go to MUL_BUSY. mul_start=1 in the first MUL_BUSY cycle only.
- IDLE + accepted DIV/DIVU, srcb!=0: latch operands, div_sign=!op[0]. Go to DIV_BUSY. div_start=1 in the first DIV_BUSY cycle only.
- IDLE + accepted DIV/DIVU, srcb==0: no launch; stay IDLE; HI/LO unchanged; div0=1 next cycle.
- IDLE + accepted MTHI/MTLO: HI (or LO) <= srca at that edge.
- MFHI/MFLO: rdata reflects the current register. Writes in the same edge become visible the following cycle; there is no bypass.
- MUL_BUSY and mul_done=1: HI<=mul_hi, LO<=mul_lo, go to IDLE. stall stays 1 in that cycle; the stalled op is accepted in the next cycle and sees the new values.
- DIV_BUSY: same as MUL_BUSY using div_done, div_hi, div_lo.
- Done signals while in IDLE, or from the unit not selected, are ignored.
- Watchdog: counter clears on entry to a busy state and increments each busy cycle. When it reaches TIMEOUT_CYCLES without the matching done: go to IDLE, HI/LO unchanged, timeout_err=1 next cycle.
- flush=1 in a busy state: go to IDLE next edge, discard the result (a done in that same cycle is also discarded), no start pulse issued afterwards.
- flush=1 in IDLE: op ignored, no state change.
- Flush has priority over done, and done has priority over timeout in the same cycle.
- Reset mid-operation: immediate return to reset values. The external unit is not told; a later stray done is ignored per the IDLE rule.
- Arithmetic: none internal. Sign selection is passed to the units; results are written unmodified.

Test Plan:
1. After reset, MFHI then MFLO -> rdata=0 both; stall=0; busy=0.
2. MTHI srca=0x12345678, next cycle MFHI -> rdata=0x12345678; LO still 0.
3. MULT srca=0xFFFFFFFE, srcb=3; unit returns done after 5 cycles with hi=0xFFFFFFFF, lo=0xFFFFFFFA; MFLO issued the cycle after MULT -> mul_start is a single pulse and mul_sign=1; stall=1 until the done cycle inclusive; MFLO then returns 0xFFFFFFFA.
4. DIVU srca=7, srcb=0 -> no div_start; div0 pulses once; HI/LO unchanged; stall=0 for the next op.
5. DIV launched, flush asserted 2 cycles later, div_done arrives 1 cycle after the flush -> busy=0; HI/LO keep their prior values; the stray done is ignored.
6. MULTU with mul_done never asserted, TIMEOUT_CYCLES=8 -> returns to IDLE after 8 busy cycles; timeout_err pulses once; a pending MFHI is accepted afterwards with the old HI.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_ctrl
//   Sequencing controller for the iterative multiplier and divider, and owner
//   of the architectural HI/LO registers. Decoded HI/LO-class ops arrive from
//   execute. MULT/DIV launch the matching unit and commit its result to HI/LO.
//   MTHI/MTLO write HI/LO. MFHI/MFLO read HI/LO. The issuing stage is stalled
//   only while an operation is in flight. Flush and a watchdog abort the
//   in-flight operation.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   op_valid, op, flush     op request from execute (op encoding below)
//   srca, srcb              rs / rt operand values
//   stall                   combinational hold for the issuing stage
//   rdata                   HI for op=110, LO for op=111, otherwise 0
//   mul_start, mul_sign     launch pulse and signedness for the multiplier
//   div_start, div_sign     launch pulse and signedness for the divider
//   opa, opb                latched operands, stable while busy
//   mul_done/hi/lo          multiplier result return
//   div_done/hi/lo          divider result return (hi=remainder, lo=quotient)
//   busy                    an operation is in flight
//   div0                    one-cycle pulse, divide by zero accepted
//   timeout_err             one-cycle pulse, watchdog abort
//   dbg_state               current FSM state, for observation only
//
// Handshake: an op is taken on a rising edge where op_valid=1, flush=0 and
//   stall=0. stall depends only on op_valid, flush and the registered state,
//   so the issuing stage may hold op_valid/op/srca/srcb steady until the
//   edge at which stall is low.
//
// op encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//              100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
// -----------------------------------------------------------------------------
module muldiv_hilo_ctrl #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             stall,
   output logic [WIDTH-1:0] rdata,
   output logic             mul_start,
   output logic             mul_sign,
   output logic             div_start,
   output logic             div_sign,
   output logic [WIDTH-1:0] opa,
   output logic [WIDTH-1:0] opb,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_hi,
   input  logic [WIDTH-1:0] mul_lo,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_hi,
   input  logic [WIDTH-1:0] div_lo,
   output logic             busy,
   output logic             div0,
   output logic             timeout_err,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_DIV_BUSY = 2'd2
   } state_t;

   // Abort on the busy cycle whose increment would make the count reach
   // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES busy cycles are spent.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               mul_sign_q, mul_sign_d;
   logic               div_sign_q, div_sign_d;
   logic               mul_start_q, mul_start_d;
   logic               div_start_q, div_start_d;
   logic               div0_q, div0_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;

   logic               is_idle;
   logic               accept;
   logic               unit_done;
   logic [WIDTH-1:0]   unit_hi;
   logic [WIDTH-1:0]   unit_lo;

   // Combinational outputs and request qualification.
   always_comb begin
      is_idle = (state_q == ST_IDLE);
      stall   = op_valid & ~flush & ~is_idle;
      accept  = op_valid & ~flush & ~stall;
      busy    = ~is_idle;
      rdata   = '0;
      if (op == 3'b110) rdata = hi_q;
      else if (op == 3'b111) rdata = lo_q;
   end

   // Only the unit that was launched may complete the operation.
   always_comb begin
      unit_done = 1'b0;
      unit_hi   = mul_hi;
      unit_lo   = mul_lo;
      if (state_q == ST_MUL_BUSY) begin
         unit_done = mul_done;
      end else if (state_q == ST_DIV_BUSY) begin
         unit_done = div_done;
         unit_hi   = div_hi;
         unit_lo   = div_lo;
      end
   end

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      mul_sign_d  = mul_sign_q;
      div_sign_d  = div_sign_q;
      mul_start_d = 1'b0;
      div_start_d = 1'b0;
      div0_d      = 1'b0;
      timeout_d   = 1'b0;
      wd_cnt_d    = wd_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  3'b000, 3'b001: begin
                     opa_d       = srca;
                     opb_d       = srcb;
                     mul_sign_d  = ~op[0];
                     mul_start_d = 1'b1;
                     wd_cnt_d    = '0;
                     state_d     = ST_MUL_BUSY;
                  end
                  3'b010, 3'b011: begin
                     // Divide by zero never reaches the divider.
                     if (srcb == '0) begin
                        div0_d = 1'b1;
                     end else begin
                        opa_d       = srca;
                        opb_d       = srcb;
                        div_sign_d  = ~op[0];
                        div_start_d = 1'b1;
                        wd_cnt_d    = '0;
                        state_d     = ST_DIV_BUSY;
                     end
                  end
                  3'b100:  hi_d = srca;
                  3'b101:  lo_d = srca;
                  default: ;
               endcase
            end
         end
         ST_MUL_BUSY, ST_DIV_BUSY: begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
            // Priority: flush, then done, then watchdog.
            if (flush) begin
               state_d = ST_IDLE;
            end else if (unit_done) begin
               hi_d    = unit_hi;
               lo_d    = unit_lo;
               state_d = ST_IDLE;
            end else if (wd_cnt_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         mul_sign_q  <= 1'b0;
         div_sign_q  <= 1'b0;
         mul_start_q <= 1'b0;
         div_start_q <= 1'b0;
         div0_q      <= 1'b0;
         timeout_q   <= 1'b0;
         wd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         mul_sign_q  <= mul_sign_d;
         div_sign_q  <= div_sign_d;
         mul_start_q <= mul_start_d;
         div_start_q <= div_start_d;
         div0_q      <= div0_d;
         timeout_q   <= timeout_d;
         wd_cnt_q    <= wd_cnt_d;
      end
   end

   assign mul_start   = mul_start_q;
   assign mul_sign    = mul_sign_q;
   assign div_start   = div_start_q;
   assign div_sign    = div_sign_q;
   assign opa         = opa_q;
   assign opb         = opb_q;
   assign div0        = div0_q;
   assign timeout_err = timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_hilo_ctrl
//   Directed and lightly randomised checks of muldiv_hilo_ctrl. Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled mid-cycle.
//   A bench model of HI/LO supplies the expected value of every MFHI/MFLO,
//   pushed to exp_q when the read is issued and popped when it is accepted.
// -----------------------------------------------------------------------------
module tb_muldiv_hilo_ctrl;

   localparam int W  = 32;
   localparam int TO = 8;

   logic          clk, reset_n;
   logic          op_valid, flush;
   logic [2:0]    op;
   logic [W-1:0]  srca, srcb;
   logic          stall, mul_start, mul_sign, div_start, div_sign;
   logic [W-1:0]  rdata, opa, opb;
   logic          mul_done, div_done;
   logic [W-1:0]  mul_hi, mul_lo, div_hi, div_lo;
   logic          busy, div0, timeout_err;
   logic [1:0]    dbg_state;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  model_hi, model_lo;
   int            n_cmp, n_err;

   muldiv_hilo_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .flush(flush),
      .srca(srca), .srcb(srcb), .stall(stall), .rdata(rdata),
      .mul_start(mul_start), .mul_sign(mul_sign),
      .div_start(div_start), .div_sign(div_sign), .opa(opa), .opb(opb),
      .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
      .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
      .busy(busy), .div0(div0), .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_time_limit: run did not finish, required finish before 200000");
      $fatal(1);
   end

   // ---------------- checking / driver tasks ----------------
   task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op_valid = 1'b1;
      op       = o;
      srca     = a;
      srcb     = b;
   endtask

   task automatic drive_idle();
      op_valid = 1'b0;
      op       = 3'b000;
      srca     = '0;
      srcb     = '0;
   endtask

   task automatic issue_mf(input logic is_lo);
      drive_op(is_lo ? 3'b111 : 3'b110, '0, '0);
      exp_q.push_back(is_lo ? model_lo : model_hi);
   endtask

   // Called at the mid-cycle sample point of the cycle the read is accepted.
   task automatic check_mf(input string tag);
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: got a read with no expected value queued", tag);
      end else begin
         check_val(tag, rdata, exp_q.pop_front());
      end
   endtask

   // Waits (bounded) for a pending MF read to be accepted, then checks it.
   task automatic mf_wait(input string tag, input int max_cyc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         #4;
         if (!stall) begin
            check_mf(tag);
            got = 1'b1;
            break;
         end
         cyc();
      end
      if (!got) check_val({tag, "_wait"}, W'(stall), '0);
   endtask

   task automatic read_both(input string tag);
      issue_mf(1'b0);
      mf_wait({tag, "_hi"}, 2);
      cyc();
      issue_mf(1'b1);
      mf_wait({tag, "_lo"}, 2);
      cyc();
      drive_idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0; n_err = 0;
      model_hi = '0; model_lo = '0;
      reset_n = 1'b0; flush = 1'b0;
      mul_done = 1'b0; div_done = 1'b0;
      mul_hi = '0; mul_lo = '0; div_hi = '0; div_lo = '0;
      drive_idle();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      #4;
      check_val("rst_busy", W'(busy), '0);
      check_val("rst_stall", W'(stall), '0);
      check_val("rst_pulses", W'({mul_start, div_start, div0, timeout_err}), '0);
      check_val("rst_signs", W'({mul_sign, div_sign}), '0);
      check_val("rst_opa", opa, '0);
      check_val("rst_opb", opb, '0);
      cyc();

      // 1: reads after reset
      read_both("t1");

      // 2: MTHI then MFHI; LO untouched. Then MTLO.
      drive_op(3'b100, 32'h1234_5678, '0);
      model_hi = 32'h1234_5678;
      cyc();
      read_both("t2");
      drive_op(3'b101, 32'hCAFE_F00D, '0);
      model_lo = 32'hCAFE_F00D;
      cyc();
      read_both("t2b");

      // 3: MULT with MFLO queued behind it
      drive_op(3'b000, 32'hFFFF_FFFE, 32'd3);
      model_hi = 32'hFFFF_FFFF;
      model_lo = 32'hFFFF_FFFA;
      #4 check_val("t3_issue_stall", W'(stall), '0);
      cyc();
      issue_mf(1'b1);
      #4;
      check_val("t3_mul_start", W'(mul_start), 32'd1);
      check_val("t3_mul_sign", W'(mul_sign), 32'd1);
      check_val("t3_opa", opa, 32'hFFFF_FFFE);
      check_val("t3_opb", opb, 32'd3);
      check_val("t3_stall_c1", W'(stall), 32'd1);
      cyc();
      for (int i = 2; i <= 5; i++) begin
         #4;
         check_val("t3_start_once", W'(mul_start), '0);
         check_val("t3_stall_busy", W'(stall), 32'd1);
         check_val("t3_opa_hold", opa, 32'hFFFF_FFFE);
         cyc();
      end
      mul_done = 1'b1; mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFFA;
      #4 check_val("t3_stall_done", W'(stall), 32'd1);
      cyc();
      mul_done = 1'b0; mul_hi = '0; mul_lo = '0;
      mf_wait("t3_mflo", 1);
      cyc();
      drive_idle();
      read_both("t3_after");

      // 4: DIVU by zero
      drive_op(3'b011, 32'd7, '0);
      #4 check_val("t4_issue_stall", W'(stall), '0);
      cyc();
      issue_mf(1'b0);
      #4;
      check_val("t4_div0", W'(div0), 32'd1);
      check_val("t4_no_start", W'(div_start), '0);
      check_val("t4_busy", W'(busy), '0);
      check_val("t4_stall", W'(stall), '0);
      check_mf("t4_mfhi");
      cyc();
      issue_mf(1'b1);
      #4;
      check_val("t4_div0_once", W'(div0), '0);
      check_mf("t4_mflo");
      cyc();
      drive_idle();

      // 5: DIV flushed, stray done afterwards
      drive_op(3'b010, 32'd100, 32'd7);
      cyc();
      drive_idle();
      #4;
      check_val("t5_div_start", W'(div_start), 32'd1);
      check_val("t5_div_sign", W'(div_sign), 32'd1);
      check_val("t5_busy", W'(busy), 32'd1);
      cyc();
      flush = 1'b1;
      #4 check_val("t5_busy_flush", W'(busy), 32'd1);
      cyc();
      flush = 1'b0;
      div_done = 1'b1; div_hi = 32'h0000_DEAD; div_lo = 32'h0000_BEEF;
      #4;
      check_val("t5_idle", W'(busy), '0);
      check_val("t5_no_restart", W'(div_start), '0);
      cyc();
      div_done = 1'b0; div_hi = '0; div_lo = '0;
      #4 check_val("t5_idle2", W'(busy), '0);
      cyc();
      read_both("t5_keep");

      // 5b: DIV completes; a stray mul_done during DIV_BUSY is ignored
      drive_op(3'b010, 32'hFFFF_FFF9, 32'd2);
      model_hi = 32'hFFFF_FFFF;
      model_lo = 32'hFFFF_FFFD;
      cyc();
      issue_mf(1'b1);
      mul_done = 1'b1; mul_hi = 32'h1111_1111; mul_lo = 32'h2222_2222;
      #4;
      check_val("t5b_opa", opa, 32'hFFFF_FFF9);
      check_val("t5b_opb", opb, 32'd2);
      check_val("t5b_stray_stall", W'(stall), 32'd1);
      cyc();
      mul_done = 1'b0;
      div_done = 1'b1; div_hi = 32'hFFFF_FFFF; div_lo = 32'hFFFF_FFFD;
      #4 check_val("t5b_stall_done", W'(stall), 32'd1);
      cyc();
      div_done = 1'b0; div_hi = '0; div_lo = '0;
      mf_wait("t5b_mflo", 1);
      cyc();
      drive_idle();

      // Stray dones while IDLE are ignored
      mul_done = 1'b1; mul_hi = 32'h3333_3333; mul_lo = 32'h4444_4444;
      div_done = 1'b1; div_hi = 32'h5555_5555; div_lo = 32'h6666_6666;
      cyc();
      mul_done = 1'b0; div_done = 1'b0;
      read_both("idle_stray");

      // 6: MULTU watchdog, MFHI pending
      drive_op(3'b001, 32'd5, 32'd6);
      cyc();
      issue_mf(1'b0);
      #4;
      check_val("t6_mul_start", W'(mul_start), 32'd1);
      check_val("t6_mul_sign", W'(mul_sign), '0);
      cyc();
      for (int i = 2; i <= TO; i++) begin
         #4;
         check_val("t6_stall_busy", W'(stall), 32'd1);
         check_val("t6_no_timeout_yet", W'(timeout_err), '0);
         cyc();
      end
      #4;
      check_val("t6_timeout_err", W'(timeout_err), 32'd1);
      check_val("t6_idle", W'(busy), '0);
      check_val("t6_stall_clear", W'(stall), '0);
      check_mf("t6_mfhi");
      cyc();
      drive_idle();
      #4 check_val("t6_timeout_once", W'(timeout_err), '0);
      cyc();

      // Random MTHI/MTLO followed by reads
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] v;
         v = W'($urandom_range(32'hFFFF_FFFF, 0));
         if ($urandom_range(1, 0) == 1) begin
            drive_op(3'b100, v, '0);
            model_hi = v;
         end else begin
            drive_op(3'b101, v, '0);
            model_lo = v;
         end
         cyc();
         read_both("rand");
      end

      // Reset in the middle of a MULT
      drive_op(3'b000, 32'd9, 32'd9);
      cyc();
      drive_idle();
      #2 reset_n = 1'b0;
      model_hi = '0;
      model_lo = '0;
      #2;
      check_val("mid_rst_busy", W'(busy), '0);
      check_val("mid_rst_start", W'(mul_start), '0);
      check_val("mid_rst_opa", opa, '0);
      cyc();
      reset_n = 1'b1;
      read_both("mid_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
